// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : fetch_queue
// Purpose  : Instruction-fetch stage downstream of the PC register. Issues
//            imem reads, tracks them through a MEM_LAT-deep request pipe and
//            buffers the returned words in a DEPTH-entry FIFO for decode.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_queue #(
  parameter int DEPTH   = 4,  // FIFO entries, power of 2, >= 2
  parameter int MEM_LAT = 1   // imem read latency in cycles, 1..3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             pc,
  output logic                    pc_hold,
  output logic                    imem_req,
  output logic [31:0]             imem_addr,
  input  logic [31:0]             imem_rdata,
  input  logic                    redirect,
  output logic                    out_valid,
  output logic [31:0]             out_instr,
  output logic [31:0]             out_pc,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // Wide enough for count (<= DEPTH) plus in-flight requests (<= 3).
  localparam int SW = CW + 2;

  // Request pipe: one {valid, pc} per cycle of memory latency.
  logic [MEM_LAT-1:0] pipe_valid;
  logic [31:0]        pipe_pc [MEM_LAT];

  // FIFO storage and bookkeeping.
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem    [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  logic [SW-1:0] inflight;
  logic [SW-1:0] occupancy;
  logic          issue;
  logic          exit_valid;
  logic [31:0]   exit_pc;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_next;
  logic [AW-1:0] rd_ptr_next;

  // Credit check and request/hold generation from registered occupancy only.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LAT; i++) begin
      inflight = inflight + SW'(pipe_valid[i]);
    end
    occupancy   = SW'(count) + inflight;
    issue       = ~reset & ~redirect & (occupancy < SW'(DEPTH));
    imem_req    = issue;
    imem_addr   = pc;
    // Hold during reset; release on redirect so the PC loads the target.
    pc_hold     = reset | (~issue & ~redirect);
    exit_valid  = pipe_valid[MEM_LAT-1];
    exit_pc     = pipe_pc[MEM_LAT-1];
    // Redirect kills returning data and any pop in the same cycle.
    push        = exit_valid & ~redirect;
    pop         = out_ready & (count != '0) & ~redirect;
    count_next  = redirect ? '0 : (count + CW'(push) - CW'(pop));
    rd_ptr_next = redirect ? '0 : (rd_ptr + AW'(pop));
    out_valid   = (count != '0);
  end

  // Shift the request pipe; redirect clears every in-flight valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      for (int i = 0; i < MEM_LAT; i++) begin
        pipe_pc[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= issue;
      pipe_pc[0]    <= pc;
      for (int i = 1; i < MEM_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1] & ~redirect;
        pipe_pc[i]    <= pipe_pc[i-1];
      end
    end
  end

  // Write returning words at the FIFO tail; storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= exit_pc;
    end
  end

  // Pointers, occupancy and the registered head copy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      out_instr <= '0;
      out_pc    <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= redirect ? '0 : (wr_ptr + AW'(push));
      count  <= count_next;
      // Head only changes when the FIFO will be non-empty; otherwise hold.
      // The head is the word being written when it lands in the head slot.
      if (count_next != '0) begin
        if (push && (wr_ptr == rd_ptr_next)) begin
          out_instr <= imem_rdata;
          out_pc    <= exit_pc;
        end else begin
          out_instr <= instr_mem[rd_ptr_next];
          out_pc    <= pc_mem[rd_ptr_next];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_queue
// Purpose  : Directed bench for fetch_queue. Instance a uses MEM_LAT=1 with
//            directed stimulus; instance b uses MEM_LAT=3 with decode always
//            ready and is checked for in-order delivery and occupancy bound.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        redirect;
  logic        out_ready;
  logic [31:0] target;

  logic [31:0] pc_a, addr_a, rdata_a, instr_a, opc_a;
  logic        hold_a, req_a, valid_a;
  logic [2:0]  cnt_a;

  logic [31:0] pc_b, addr_b, rdata_b, instr_b, opc_b;
  logic        hold_b, req_b, valid_b;
  logic [2:0]  cnt_b;

  int n_vec = 0;
  int n_err = 0;
  int nreq;
  int b_pops = 0;
  logic [31:0] exp_b = 32'h0;

  fetch_queue #(.DEPTH(4), .MEM_LAT(1)) u_a (
    .clk(clk), .reset(reset), .pc(pc_a), .pc_hold(hold_a),
    .imem_req(req_a), .imem_addr(addr_a), .imem_rdata(rdata_a),
    .redirect(redirect), .out_valid(valid_a), .out_instr(instr_a),
    .out_pc(opc_a), .out_ready(out_ready), .count(cnt_a)
  );

  fetch_queue #(.DEPTH(4), .MEM_LAT(3)) u_b (
    .clk(clk), .reset(reset), .pc(pc_b), .pc_hold(hold_b),
    .imem_req(req_b), .imem_addr(addr_b), .imem_rdata(rdata_b),
    .redirect(1'b0), .out_valid(valid_b), .out_instr(instr_b),
    .out_pc(opc_b), .out_ready(1'b1), .count(cnt_b)
  );

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a ^ 32'h1234_5678;
  endfunction

  // PC registers: load next PC (or redirect target) when not held.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_a <= 32'h0;
      pc_b <= 32'h0;
    end else begin
      if (!hold_a) pc_a <= redirect ? target : pc_a + 32'd4;
      if (!hold_b) pc_b <= pc_b + 32'd4;
    end
  end

  // Instruction memories with 1 and 3 cycles of read latency.
  logic [31:0] a_d1, b_d1, b_d2, b_d3;
  always @(posedge clk) begin
    a_d1 <= addr_a;
    b_d1 <= addr_b;
    b_d2 <= b_d1;
    b_d3 <= b_d2;
  end
  assign rdata_a = imem_word(a_d1);
  assign rdata_b = imem_word(b_d3);

  // Outstanding-request history for instance b.
  logic [2:0] vb;
  always @(posedge clk or posedge reset) begin
    if (reset) vb <= 3'b0;
    else       vb <= {vb[1:0], req_b};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instance b: in-order, no loss/duplication, occupancy never above DEPTH.
  always @(negedge clk) begin
    int occ;
    if (reset) begin
      exp_b = 32'h0;
    end else begin
      occ = int'(cnt_b) + int'(vb[0]) + int'(vb[1]) + int'(vb[2]);
      chk("b_occ_le4", {31'b0, occ <= 4}, 32'd1);
      if (valid_b) begin
        chk("b_pc", opc_b, exp_b);
        chk("b_instr", instr_b, imem_word(exp_b));
        exp_b  = exp_b + 32'd4;
        b_pops = b_pops + 1;
      end
    end
  end

  initial begin
    reset = 1'b1; redirect = 1'b0; out_ready = 1'b1; target = 32'h0;
    repeat (2) step();
    chk("rst_valid", {31'b0, valid_a}, 32'd0);
    chk("rst_count", {29'b0, cnt_a}, 32'd0);
    chk("rst_req",   {31'b0, req_a}, 32'd0);
    chk("rst_hold",  {31'b0, hold_a}, 32'd1);
    chk("rst_pc",    opc_a, 32'h0);
    chk("rst_instr", instr_a, 32'h0);

    // Streaming with decode ready: latency 2, in order, hold stays low.
    reset = 1'b0; #1;
    chk("t1_req0",  {31'b0, req_a}, 32'd1);
    chk("t1_addr0", addr_a, 32'h0);
    chk("t1_hold0", {31'b0, hold_a}, 32'd0);
    step();
    chk("t1_req1",   {31'b0, req_a}, 32'd1);
    chk("t1_addr1",  addr_a, 32'h4);
    chk("t1_valid1", {31'b0, valid_a}, 32'd0);
    step();
    chk("t1_valid2", {31'b0, valid_a}, 32'd1);
    chk("t1_pc0",    opc_a, 32'h0);
    chk("t1_instr0", instr_a, imem_word(32'h0));
    chk("t1_cnt2",   {29'b0, cnt_a}, 32'd1);
    step();
    chk("t1_pc4",    opc_a, 32'h4);
    chk("t1_instr4", instr_a, imem_word(32'h4));
    chk("t6_cnt",    {29'b0, cnt_a}, 32'd1);
    chk("t1_hold3",  {31'b0, hold_a}, 32'd0);
    step();
    chk("t1_pc8",    opc_a, 32'h8);
    chk("t6_cnt2",   {29'b0, cnt_a}, 32'd1);

    // Decode stalled: exactly DEPTH requests, then hold.
    reset = 1'b1; step();
    reset = 1'b0; out_ready = 1'b0; #1;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      nreq += int'(req_a);
      step();
    end
    chk("t2_nreq",  32'(nreq), 32'd4);
    chk("t2_cnt",   {29'b0, cnt_a}, 32'd4);
    chk("t2_hold",  {31'b0, hold_a}, 32'd1);
    chk("t2_req",   {31'b0, req_a}, 32'd0);
    chk("t2_head",  opc_a, 32'h0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("t2_cnt3",  {29'b0, cnt_a}, 32'd3);
    chk("t2_rereq", {31'b0, req_a}, 32'd1);
    chk("t2_addr",  addr_a, 32'h10);
    chk("t2_head4", opc_a, 32'h4);
    step();
    chk("t2_noreq", {31'b0, req_a}, 32'd0);
    chk("t2_cnt3b", {29'b0, cnt_a}, 32'd3);

    // Redirect with 3 buffered and 1 in flight.
    redirect = 1'b1; target = 32'h100; #1;
    chk("t3_hold",  {31'b0, hold_a}, 32'd0);
    chk("t3_req",   {31'b0, req_a}, 32'd0);
    step(); redirect = 1'b0; #1;
    chk("t3_cnt0",  {29'b0, cnt_a}, 32'd0);
    chk("t3_valid", {31'b0, valid_a}, 32'd0);
    chk("t3_req1",  {31'b0, req_a}, 32'd1);
    chk("t3_addr",  addr_a, 32'h100);
    out_ready = 1'b1;
    step();
    chk("t3_valid1", {31'b0, valid_a}, 32'd0);
    chk("t3_cnt1",   {29'b0, cnt_a}, 32'd0);
    step();
    chk("t3_valid2", {31'b0, valid_a}, 32'd1);
    chk("t3_pc",     opc_a, 32'h100);
    chk("t3_instr",  instr_a, imem_word(32'h100));

    // Asynchronous reset between edges.
    #2; reset = 1'b1; #1;
    chk("t4_valid", {31'b0, valid_a}, 32'd0);
    chk("t4_cnt",   {29'b0, cnt_a}, 32'd0);
    chk("t4_req",   {31'b0, req_a}, 32'd0);
    chk("t4_hold",  {31'b0, hold_a}, 32'd1);
    chk("t4_pc",    opc_a, 32'h0);
    step(); step();
    reset = 1'b0; b_pops = 0; #1;
    chk("t4_req1",  {31'b0, req_a}, 32'd1);
    chk("t4_addr",  addr_a, 32'h0);

    // Let instance b stream for a while.
    repeat (20) step();
    chk("t5_b_pops", {31'b0, b_pops >= 10}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
